// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 2-column shift window feed s1..s9.
// Optional WIN3_SOF_RESYNC_EN adds in_sof to force the frame position back to (row 0, col 0).
module window3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef WIN3_SOF_RESYNC_EN
  input  logic              in_sof,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] s1,
  output logic [DATA_W-1:0] s2,
  output logic [DATA_W-1:0] s3,
  output logic [DATA_W-1:0] s4,
  output logic [DATA_W-1:0] s5,
  output logic [DATA_W-1:0] s6,
  output logic [DATA_W-1:0] s7,
  output logic [DATA_W-1:0] s8,
  output logic [DATA_W-1:0] s9,
  output logic              out_last
);

  // state  | meaning
  // S_FILL | rows 0..1, line buffers priming, no windows
  // S_RUN  | rows 2..IMG_H-1, windows emitted for col >= 2
  typedef enum logic {S_FILL, S_RUN} state_t;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  state_t          state, state_nxt, state_eff;
  logic [CW-1:0]   col, col_nxt, col_eff;
  logic [RW-1:0]   row, row_nxt, row_eff;
  logic            accept, emit, last_hit, sof;

  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];
  logic [DATA_W-1:0] lb_a_rd, lb_b_rd;
  logic [DATA_W-1:0] w0_t, w0_m, w0_b;
  logic [DATA_W-1:0] w1_t, w1_m, w1_b;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef WIN3_SOF_RESYNC_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  // A start-of-frame pixel is handled exactly as if the counters already sat at (0,0).
  always_comb begin
    col_eff   = col;
    row_eff   = row;
    state_eff = state;
    if (sof) begin
      col_eff   = '0;
      row_eff   = '0;
      state_eff = S_FILL;
    end
  end

  assign lb_a_rd = lb_a[col_eff];
  assign lb_b_rd = lb_b[col_eff];

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    emit      = 1'b0;
    last_hit  = 1'b0;
    if (accept) begin
      last_hit  = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      emit      = (state_eff == S_RUN) && (col_eff >= COL_TWO);
      state_nxt = state_eff;
      row_nxt   = row_eff;
      if (col_eff == COL_LAST) begin
        col_nxt = '0;
        row_nxt = last_hit ? '0 : row_eff + 1'b1;
      end else begin
        col_nxt = col_eff + 1'b1;
      end
      if ((state_eff == S_FILL) && (row_eff == ROW_ONE) && (col_eff == COL_LAST)) begin
        state_nxt = S_RUN;
      end else if ((state_eff == S_RUN) && last_hit) begin
        state_nxt = S_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FILL;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Line buffers and window columns need no reset: stale data is never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b[col_eff] <= lb_a_rd;
      lb_a[col_eff] <= in_data;
      w0_t <= w1_t;
      w0_m <= w1_m;
      w0_b <= w1_b;
      w1_t <= lb_b_rd;
      w1_m <= lb_a_rd;
      w1_b <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
      s5 <= '0;
      s6 <= '0;
      s7 <= '0;
      s8 <= '0;
      s9 <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_last  <= last_hit;
      s1 <= w0_t;
      s2 <= w1_t;
      s3 <= lb_b_rd;
      s4 <= w0_m;
      s5 <= w1_m;
      s6 <= lb_a_rd;
      s7 <= w0_b;
      s8 <= w1_b;
      s9 <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 5x4 image: a 2-D image model predicts every window,
// and a few literal windows pin the model.
`timescale 1ns/1ps
module tb_window3x3_gen;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  typedef logic [72:0] win_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last;
  logic [DW-1:0] s1, s2, s3, s4, s5, s6, s7, s8, s9;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] img [H][W];
  int   mr = 0;
  int   mc = 0;
  win_t exp_q[$];
  win_t got_log[$];
  win_t cur_win;

  always #5 clk = ~clk;

  window3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef WIN3_SOF_RESYNC_EN
    .in_sof(in_sof),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s1(s1), .s2(s2), .s3(s3),
    .s4(s4), .s5(s5), .s6(s6),
    .s7(s7), .s8(s8), .s9(s9),
    .out_last(out_last)
  );

  assign cur_win = {s1, s2, s3, s4, s5, s6, s7, s8, s9, out_last};

  task automatic chk(input string name, input win_t got, input win_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic win_t win(input int a, input int b, input int c, input int d, input int e,
                               input int f, input int g, input int h, input int i, input bit l);
    return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i), l};
  endfunction

  // Image-level model: every pixel with a full 3x3 neighbourhood above-left yields a window.
  task automatic model_accept(input logic [DW-1:0] d, input logic sof);
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = d;
    if (mr >= 2 && mc >= 2)
      exp_q.push_back({img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                       img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                       img[mr][mc-2],   img[mr][mc-1],   img[mr][mc],
                       (mr == H-1) && (mc == W-1)});
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_window", win_t'(out_valid), win_t'(0));
      end else begin
        chk("window", cur_win, exp_q[0]);
        if (!out_ready) chk("stall_in_ready", win_t'(in_ready), win_t'(0));
        if (out_ready) begin
          got_log.push_back(cur_win);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_pix(input int d, input logic sof);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_sof   = sof;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
      if (n > 100) begin
        chk("in_ready_timeout", win_t'(in_ready), win_t'(1));
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) model_accept(DW'(d), sof);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input logic sof_first);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(r*W + c + base, (r == 0 && c == 0) ? sof_first : 1'b0);
  endtask

  task automatic drain(input int expected);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", win_t'(exp_q.size()), win_t'(0));
    chk("window_count", win_t'(got_log.size()), win_t'(expected));
  endtask

  task automatic check_ends(input string tag, input int first_idx, input int base);
    if (got_log.size() > first_idx + 5) begin
      chk({tag, "_first"}, got_log[first_idx],
          win(base+0, base+1, base+2, base+5, base+6, base+7, base+10, base+11, base+12, 1'b0));
      chk({tag, "_last"}, got_log[first_idx+5],
          win(base+7, base+8, base+9, base+12, base+13, base+14, base+17, base+18, base+19, 1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset with traffic offered
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", win_t'(out_valid), win_t'(0));
    chk("rst_out_last", win_t'(out_last), win_t'(0));
    chk("rst_in_ready", win_t'(in_ready), win_t'(1));
    chk("rst_window", win_t'({s1, s2, s3, s4, s5, s6, s7, s8, s9}), win_t'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // single frame, always ready
    got_log.delete();
    send_frame(0, 1'b0);
    drain(6);
    check_ends("frame", 0, 0);

    // output stall of 3 cycles mid-stream
    got_log.delete();
    fork
      send_frame(0, 1'b0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 200);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(6);
    check_ends("stall", 0, 0);

    // two frames back-to-back
    got_log.delete();
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain(12);
    check_ends("b2b_f1", 0, 0);
    check_ends("b2b_f2", 6, 100);

    // reset mid-frame after 7 pixels
    got_log.delete();
    for (int i = 0; i < 7; i++) send_pix(200 + i, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    mr = 0;
    mc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(0, 1'b0);
    drain(6);
    check_ends("midrst", 0, 0);

`ifdef WIN3_SOF_RESYNC_EN
    // garbage then start-of-frame resync
    got_log.delete();
    for (int i = 0; i < 3; i++) send_pix(250 + i, 1'b0);
    send_frame(0, 1'b1);
    drain(6);
    check_ends("sof", 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
